// File: rtl/itrx_aib_phy_rst_seq.sv
// AIB PHY reset sequencer: releases local/near/far resets in order, watching resynchronised far-end acks.
// Build option ITRX_AIB_RST_TMO_EN adds the handshake timeout and the sticky ERR state.
module itrx_aib_phy_rst_seq #(
  parameter int WAIT_CYC = 16,
  parameter int TMO_CYC  = 4096,
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ms_nsl,
  input  logic       device_detect,
  input  logic       por_out,
  input  logic       rstn_out,
  input  logic       adap_rstn_out,
  output logic       adapt_rstn,
  output logic       rstn_in,
  output logic       adap_rstn_in,
  output logic       link_up,
  output logic       tmo_err,
  output logic [2:0] seq_state
);

  localparam int MAXC = (WAIT_CYC > TMO_CYC) ? WAIT_CYC : TMO_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef ITRX_AIB_RST_TMO_EN
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PHY_REL = 3'd1,
    LNK_REL = 3'd2,
    ADP_DLY = 3'd3,
    ADP_REL = 3'd4,
    LINK_UP = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cnt;
  logic [SYNC_STG-1:0] rstn_sync, adap_sync, dd_sync, por_sync;
  logic            rstn_s, adap_s, presence, wait_done;
  logic            adapt_nxt, rstn_in_nxt, adap_in_nxt, link_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstn_sync <= '0;
      adap_sync <= '0;
      dd_sync   <= '0;
      por_sync  <= '0;
    end else begin
      rstn_sync <= {rstn_sync[SYNC_STG-2:0], rstn_out};
      adap_sync <= {adap_sync[SYNC_STG-2:0], adap_rstn_out};
      dd_sync   <= {dd_sync[SYNC_STG-2:0], device_detect};
      por_sync  <= {por_sync[SYNC_STG-2:0], por_out};
    end
  end

  assign rstn_s    = rstn_sync[SYNC_STG-1];
  assign adap_s    = adap_sync[SYNC_STG-1];
  assign presence  = ms_nsl ? ~por_sync[SYNC_STG-1] : dd_sync[SYNC_STG-1];
  assign wait_done = (cnt >= WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)    cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enable && presence) nxt = PHY_REL;
      PHY_REL: if (wait_done) nxt = LNK_REL;
      LNK_REL: begin
        if (rstn_s) nxt = ADP_DLY;
`ifdef ITRX_AIB_RST_TMO_EN
        else if (cnt >= TMO_LAST) nxt = ERR;
`endif
      end
      ADP_DLY: if (wait_done) nxt = ADP_REL;
      ADP_REL: begin
        if (adap_s) nxt = LINK_UP;
`ifdef ITRX_AIB_RST_TMO_EN
        else if (cnt >= TMO_LAST) nxt = ERR;
`endif
      end
      LINK_UP: if (!(rstn_s && adap_s)) nxt = IDLE;
`ifdef ITRX_AIB_RST_TMO_EN
      ERR:     nxt = ERR;
`endif
      default: nxt = IDLE;
    endcase
    // Disable and presence loss override any handshake progress; ERR only leaves on disable.
    if (!enable)                        nxt = IDLE;
    else if (!presence && state != ERR) nxt = IDLE;
  end

  always_comb begin
    adapt_nxt   = (nxt >= PHY_REL) && (nxt <= LINK_UP);
    rstn_in_nxt = (nxt >= LNK_REL) && (nxt <= LINK_UP);
    adap_in_nxt = (nxt == ADP_REL) || (nxt == LINK_UP);
    link_nxt    = (nxt == LINK_UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adapt_rstn   <= 1'b0;
      rstn_in      <= 1'b0;
      adap_rstn_in <= 1'b0;
      link_up      <= 1'b0;
    end else begin
      adapt_rstn   <= adapt_nxt;
      rstn_in      <= rstn_in_nxt;
      adap_rstn_in <= adap_in_nxt;
      link_up      <= link_nxt;
    end
  end

`ifdef ITRX_AIB_RST_TMO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_err <= 1'b0;
    else        tmo_err <= (nxt == ERR);
  end
`else
  assign tmo_err = 1'b0;
`endif

  assign seq_state = state;

endmodule

// File: tb/tb_itrx_aib_phy_rst_seq.sv
// Directed bench for itrx_aib_phy_rst_seq (WAIT_CYC=4, TMO_CYC=32, SYNC_STG=2).
module tb_itrx_aib_phy_rst_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0, enable = 1'b0, ms_nsl = 1'b1;
  logic device_detect = 1'b0, por_out = 1'b0, rstn_out = 1'b0, adap_rstn_out = 1'b0;
  logic adapt_rstn, rstn_in, adap_rstn_in, link_up, tmo_err;
  logic [2:0] seq_state;
  logic [4:0] outs;
  int checks = 0;
  int errors = 0;

  itrx_aib_phy_rst_seq #(.WAIT_CYC(4), .TMO_CYC(32), .SYNC_STG(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ms_nsl(ms_nsl),
    .device_detect(device_detect), .por_out(por_out), .rstn_out(rstn_out),
    .adap_rstn_out(adap_rstn_out), .adapt_rstn(adapt_rstn), .rstn_in(rstn_in),
    .adap_rstn_in(adap_rstn_in), .link_up(link_up), .tmo_err(tmo_err),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // {adapt_rstn, rstn_in, adap_rstn_in, link_up, tmo_err}
  assign outs = {adapt_rstn, rstn_in, adap_rstn_in, link_up, tmo_err};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_state", 8'(seq_state), 8'd0);
    chk("rst_outs", 8'(outs), 8'b00000);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_enable", 8'(seq_state), 8'd0);

    // Master happy path
    enable = 1'b1;
    step(1);  chk("m_phy_rel", 8'(seq_state), 8'd1);  chk("m_adapt_p1", 8'(outs), 8'b10000);
    step(3);  chk("m_phy_rel_end", 8'(seq_state), 8'd1);
    step(1);  chk("m_lnk_rel", 8'(seq_state), 8'd2);  chk("m_rstn_in_p5", 8'(outs), 8'b11000);
    step(5);  rstn_out = 1'b1;
    step(2);  chk("m_lnk_wait_sync", 8'(seq_state), 8'd2);
    step(1);  chk("m_adp_dly", 8'(seq_state), 8'd3);  chk("m_adp_dly_outs", 8'(outs), 8'b11000);
    step(3);  chk("m_adp_dly_end", 8'(seq_state), 8'd3);
    step(1);  chk("m_adp_rel", 8'(seq_state), 8'd4);  chk("m_adp_rel_outs", 8'(outs), 8'b11100);
    step(3);  adap_rstn_out = 1'b1;
    step(2);  chk("m_pre_linkup", 8'(outs), 8'b11100);
    step(1);  chk("m_link_up", 8'(seq_state), 8'd5);  chk("m_link_up_outs", 8'(outs), 8'b11110);
    step(5);  chk("m_link_hold", 8'(seq_state), 8'd5);

    // Far adapter drop while up, then re-sequence
    adap_rstn_out = 1'b0;
    step(2);  chk("drop_not_yet", 8'(outs), 8'b11110);
    step(1);  chk("drop_idle", 8'(seq_state), 8'd0);  chk("drop_outs", 8'(outs), 8'b00000);
    step(1);  chk("reseq_phy_rel", 8'(seq_state), 8'd1);
    step(4);  chk("reseq_lnk_rel", 8'(seq_state), 8'd2);
    step(1);  chk("reseq_adp_dly", 8'(seq_state), 8'd3);

    // Disable inside ADP_DLY
    step(1);  enable = 1'b0;
    step(1);  chk("abort_en_state", 8'(seq_state), 8'd0);  chk("abort_en_outs", 8'(outs), 8'b00000);
    enable = 1'b1;
    step(1);  chk("abort_re_phy", 8'(seq_state), 8'd1);
    step(3);  chk("abort_cnt_clr", 8'(seq_state), 8'd1);
    step(1);  chk("abort_re_lnk", 8'(seq_state), 8'd2);
    step(1);  chk("abort_re_dly", 8'(seq_state), 8'd3);
    step(4);  chk("abort_re_adp", 8'(seq_state), 8'd4);

    // Synchronous reset inside ADP_REL
    rst_n = 1'b0;
    step(1);  chk("abort_rst_state", 8'(seq_state), 8'd0);  chk("abort_rst_outs", 8'(outs), 8'b00000);

    // Handshake never returns
    rstn_out = 1'b0;
    enable = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    enable = 1'b1;
    step(1);  chk("t_phy_rel", 8'(seq_state), 8'd1);
    step(4);  chk("t_lnk_rel", 8'(seq_state), 8'd2);
`ifdef ITRX_AIB_RST_TMO_EN
    step(31); chk("t_last_wait", 8'(seq_state), 8'd2);  chk("t_last_outs", 8'(outs), 8'b11000);
    step(1);  chk("t_err", 8'(seq_state), 8'd6);  chk("t_err_outs", 8'(outs), 8'b00001);
    step(10); chk("t_err_sticky", 8'(outs), 8'b00001);
    enable = 1'b0;
    step(1);  chk("t_err_clear", 8'(seq_state), 8'd0);  chk("t_err_clr_outs", 8'(outs), 8'b00000);
`else
    step(1000); chk("t_no_tmo_state", 8'(seq_state), 8'd2);  chk("t_no_tmo_outs", 8'(outs), 8'b11000);
    rstn_out = 1'b1;
    step(3);  chk("t_no_tmo_proceed", 8'(seq_state), 8'd3);
    enable = 1'b0;
    step(1);  chk("t_no_tmo_idle", 8'(seq_state), 8'd0);
`endif

    // Slave gating on device_detect
    rst_n = 1'b0;
    ms_nsl = 1'b0;
    device_detect = 1'b0;
    rstn_out = 1'b0;
    step(2);
    rst_n = 1'b1;
    enable = 1'b1;
    step(100); chk("s_gated_state", 8'(seq_state), 8'd0);  chk("s_gated_outs", 8'(outs), 8'b00000);
    device_detect = 1'b1;
    step(2);  chk("s_sync_wait", 8'(seq_state), 8'd0);
    step(1);  chk("s_phy_rel", 8'(seq_state), 8'd1);  chk("s_phy_outs", 8'(outs), 8'b10000);

    // Presence lost mid-sequence
    device_detect = 1'b0;
    step(2);  chk("s_loss_sync", 8'(seq_state), 8'd1);
    step(1);  chk("s_loss_idle", 8'(seq_state), 8'd0);  chk("s_loss_outs", 8'(outs), 8'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
